// File: rtl/reaction_pkg.sv
// Shared definitions for the multi-player reaction timer: state encoding,
// "no best time" marker and LFSR seed/taps.
package reaction_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_GO    = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam logic [13:0] NO_BEST   = 14'h3FFF;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // taps 16,14,13,11 counted from 1 at the LSB end
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for one raw button.
module btn_sync_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_edge
);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic       r_edge;
   logic [1:0] r_settle;

   // r_prev is held high until the synchroniser has filled, so a button held
   // through reset looks "already pressed" and needs a release first.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_prev   <= 1'b1;
         r_edge   <= 1'b0;
         r_settle <= 2'b00;
      end else begin
         r_sync1  <= i_btn;
         r_sync2  <= r_sync1;
         r_settle <= {r_settle[0], 1'b1};
         r_prev   <= r_settle[1] ? r_sync2 : 1'b1;
         r_edge   <= r_sync2 & ~r_prev;
      end
   end

   assign o_edge = r_edge;

endmodule

// File: rtl/multi_reaction_timer.sv
// Reaction-time game: random pre-GO delay, per-player reaction timing in ms,
// false-start detection, timeout and best-time tracking.
module multi_reaction_timer
   import reaction_pkg::*;
#(
   parameter int N_PLAYERS       = 2,
   parameter int CLK_PER_MS      = 10000,
   parameter int MIN_DELAY_MS    = 1000,
   parameter int DELAY_SPAN_LOG2 = 11,
   parameter int MAX_MS          = 9999
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start_btn,
   input  logic [N_PLAYERS-1:0] i_react_btn,
   output logic                 o_led,
   output logic [13:0]          o_time_ms,
   output logic [13:0]          o_best_ms,
   output logic [1:0]           o_winner,
   output logic                 o_false_start,
   output logic                 o_timeout,
   output logic                 o_result_valid,
   output logic [2:0]           o_state
);

   localparam int              PW         = $clog2(CLK_PER_MS);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_MS - 1);
   localparam logic [13:0]     MAX_T      = 14'(MAX_MS);
   localparam logic [15:0]     MIN_D      = 16'(MIN_DELAY_MS);

   state_t               r_state;
   state_t               w_state_next;
   logic [15:0]          r_lfsr;
   logic [15:0]          r_delay;
   logic [PW-1:0]        r_presc;
   logic [13:0]          r_time;
   logic [13:0]          r_best;
   logic [13:0]          w_time_inc;
   logic [1:0]           r_winner;
   logic [1:0]           w_react_idx;
   logic                 r_false_start;
   logic                 r_timeout;
   logic                 r_result_valid;
   logic                 w_start_edge;
   logic                 w_tick;
   logic                 w_react_any;
   logic                 w_entering;
   logic                 w_timeout_hit;
   logic                 w_led;
   logic [N_PLAYERS-1:0] w_react_edge;

   btn_sync_edge u_start_sync (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_btn  (i_start_btn),
      .o_edge (w_start_edge)
   );

   for (genvar g = 0; g < N_PLAYERS; g++) begin : g_react
      btn_sync_edge u_react_sync (
         .i_clk  (i_clk),
         .i_rst_n(i_rst_n),
         .i_btn  (i_react_btn[g]),
         .o_edge (w_react_edge[g])
      );
   end

   assign w_tick        = (r_presc == PRESC_LAST);
   assign w_react_any   = |w_react_edge;
   assign w_react_idx   = lowest_set(4'(w_react_edge));
   assign w_time_inc    = r_time + 14'd1;
   assign w_timeout_hit = w_tick && (w_time_inc >= MAX_T);
   assign w_entering    = (w_state_next != r_state);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_led        = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (w_start_edge) w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (w_react_any)        w_state_next = ST_ERROR;
            else if (r_delay == '0) w_state_next = ST_GO;
         end
         ST_GO: begin
            w_led = 1'b1;
            if (w_react_any || w_timeout_hit) w_state_next = ST_DONE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr         <= LFSR_SEED;
         r_presc        <= '0;
         r_delay        <= '0;
         r_time         <= '0;
         r_best         <= NO_BEST;
         r_winner       <= '0;
         r_false_start  <= 1'b0;
         r_timeout      <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_lfsr         <= lfsr_next(r_lfsr);
         r_result_valid <= w_entering &&
                           (w_state_next == ST_DONE || w_state_next == ST_ERROR);
         // each phase measures from a fresh millisecond boundary
         if (w_entering && (w_state_next == ST_WAIT || w_state_next == ST_GO))
            r_presc <= '0;
         else if (w_tick)
            r_presc <= '0;
         else
            r_presc <= r_presc + 1'b1;

         case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (w_start_edge) begin
                  r_delay       <= MIN_D + 16'(r_lfsr[DELAY_SPAN_LOG2-1:0]);
                  r_false_start <= 1'b0;
                  r_timeout     <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (w_react_any) begin
                  r_winner      <= w_react_idx;
                  r_false_start <= 1'b1;
               end else if (r_delay == '0) begin
                  r_time <= '0;
               end else if (w_tick) begin
                  r_delay <= r_delay - 16'd1;
               end
            end
            ST_GO: begin
               // a press wins over a coincident tick, so the pre-increment time is kept
               if (w_react_any) begin
                  r_winner <= w_react_idx;
                  if (r_time < r_best) r_best <= r_time;
               end else if (w_timeout_hit) begin
                  r_time    <= MAX_T;
                  r_timeout <= 1'b1;
               end else if (w_tick) begin
                  r_time <= w_time_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_led          = w_led;
   assign o_time_ms      = r_time;
   assign o_best_ms      = r_best;
   assign o_winner       = r_winner;
   assign o_false_start  = r_false_start;
   assign o_timeout      = r_timeout;
   assign o_result_valid = r_result_valid;
   assign o_state        = r_state;

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Self-checking bench for multi_reaction_timer with small timing parameters.
module tb_multi_reaction_timer;

   localparam int C     = 4;
   localparam int MIN_D = 2;
   localparam int MAXT  = 20;
   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_GO = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        start_btn = 1'b0;
   logic [1:0]  react_btn = 2'b00;
   logic        led, false_start, timeout, result_valid;
   logic [13:0] time_ms, best_ms;
   logic [1:0]  winner;
   logic [2:0]  state;

   int          n_checks   = 0;
   int          n_errors   = 0;
   int          exp_time   = 0;
   int          exp_best   = 16383;
   int          exp_winner = 0;
   logic [2:0]  exp_state  = 3'd0;
   logic [15:0] m_lfsr     = 16'hACE1;
   logic [15:0] m_used     = 16'hACE1;

   always #5 clk = ~clk;

   multi_reaction_timer #(
      .N_PLAYERS(2), .CLK_PER_MS(C), .MIN_DELAY_MS(MIN_D),
      .DELAY_SPAN_LOG2(2), .MAX_MS(MAXT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start_btn(start_btn), .i_react_btn(react_btn),
      .o_led(led), .o_time_ms(time_ms), .o_best_ms(best_ms), .o_winner(winner),
      .o_false_start(false_start), .o_timeout(timeout), .o_result_valid(result_valid),
      .o_state(state)
   );

   // Reference LFSR: one step per clock since reset; m_used is the value
   // that was current at the most recent rising edge.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 16'hACE1;
         m_used <= 16'hACE1;
      end else begin
         m_used <= m_lfsr;
         m_lfsr <= lfsr_step(m_lfsr);
      end
   end

   function automatic int lowest(input logic [1:0] w);
      return w[0] ? 0 : 1;
   endfunction

   task automatic start_round(output int d);
      start_btn = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (state !== exp_state) begin n_errors++; $display("FAIL start_latency: state %0d expected %0d", state, exp_state); end
      @(negedge clk);
      n_checks++;
      if (state !== S_WAIT) begin n_errors++; $display("FAIL wait_entry: state %0d expected %0d", state, S_WAIT); end
      n_checks++;
      if ({false_start, timeout} !== 2'b00) begin n_errors++; $display("FAIL wait_flags_clear: fs/to %b expected 00", {false_start, timeout}); end
      n_checks++;
      if (winner !== 2'(exp_winner)) begin n_errors++; $display("FAIL winner_hold: got %0d expected %0d", winner, exp_winner); end
      d = MIN_D + int'(m_used[1:0]);
      start_btn = 1'b0;
      exp_state = S_WAIT;
   endtask

   task automatic wait_for_go(input int d);
      int n = 0;
      while (led !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      n_checks++;
      if (n != d * C + 1) begin n_errors++; $display("FAIL wait_length: got %0d cycles expected %0d", n, d * C + 1); end
      n_checks++;
      if (time_ms !== 14'd0) begin n_errors++; $display("FAIL go_time_clear: got %0d expected 0", time_ms); end
      exp_state = S_GO;
   endtask

   // p < 0: no press. Otherwise pins 'who' are raised p cycles into GO.
   task automatic run_round(input int p, input logic [1:0] who, input logic poke_start);
      int   d, cur, exp_cycle;
      logic to;
      start_round(d);
      wait_for_go(d);
      if (poke_start) start_btn = 1'b1;
      cur = 0;
      if (p >= 0) begin
         repeat (p) @(negedge clk);
         cur = p;
         react_btn = who;
      end
      to = (p < 0) || (p + 3 >= MAXT * C);
      exp_cycle = to ? MAXT * C : p + 4;
      while (state !== S_DONE && state !== S_ERR && cur < 400) begin @(negedge clk); cur++; end
      if (to) exp_time = MAXT;
      else begin
         exp_time   = (p + 3) / C;
         exp_winner = lowest(who);
         if (exp_time < exp_best) exp_best = exp_time;
      end
      n_checks++;
      if (cur != exp_cycle) begin n_errors++; $display("FAIL done_cycle: got %0d expected %0d", cur, exp_cycle); end
      n_checks++;
      if (state !== S_DONE) begin n_errors++; $display("FAIL done_state: got %0d expected %0d", state, S_DONE); end
      n_checks++;
      if (time_ms !== 14'(exp_time)) begin n_errors++; $display("FAIL done_time: got %0d expected %0d", time_ms, exp_time); end
      n_checks++;
      if (timeout !== to) begin n_errors++; $display("FAIL done_timeout: got %b expected %b", timeout, to); end
      n_checks++;
      if (winner !== 2'(exp_winner)) begin n_errors++; $display("FAIL done_winner: got %0d expected %0d", winner, exp_winner); end
      n_checks++;
      if (best_ms !== 14'(exp_best)) begin n_errors++; $display("FAIL done_best: got %0d expected %0d", best_ms, exp_best); end
      n_checks++;
      if ({result_valid, led, false_start} !== 3'b100) begin n_errors++; $display("FAIL done_flags: rv/led/fs %b expected 100", {result_valid, led, false_start}); end
      @(negedge clk);
      n_checks++;
      if ({result_valid, state} !== {1'b0, S_DONE}) begin n_errors++; $display("FAIL done_pulse_end: rv %b state %0d expected 0 and %0d", result_valid, state, S_DONE); end
      react_btn = 2'b00;
      start_btn = 1'b0;
      exp_state = S_DONE;
      repeat (2) @(negedge clk);
   endtask

   task automatic false_start_round(input logic [1:0] who);
      int   d, q, cur;
      logic lit;
      start_round(d);
      q = int'($urandom_range(0, d * C - 3));
      lit = 1'b0;
      repeat (q) begin @(negedge clk); lit |= led; end
      react_btn = who;
      cur = q;
      while (state !== S_ERR && cur < q + 50) begin @(negedge clk); cur++; lit |= led; end
      exp_winner = lowest(who);
      n_checks++;
      if (cur != q + 4) begin n_errors++; $display("FAIL error_cycle: got %0d expected %0d", cur, q + 4); end
      n_checks++;
      if (lit !== 1'b0) begin n_errors++; $display("FAIL led_in_wait: got %b expected 0", lit); end
      n_checks++;
      if ({false_start, timeout, result_valid} !== 3'b101) begin n_errors++; $display("FAIL error_flags: fs/to/rv %b expected 101", {false_start, timeout, result_valid}); end
      n_checks++;
      if (winner !== 2'(exp_winner)) begin n_errors++; $display("FAIL error_winner: got %0d expected %0d", winner, exp_winner); end
      n_checks++;
      if (time_ms !== 14'(exp_time)) begin n_errors++; $display("FAIL error_time_hold: got %0d expected %0d", time_ms, exp_time); end
      n_checks++;
      if (best_ms !== 14'(exp_best)) begin n_errors++; $display("FAIL error_best_hold: got %0d expected %0d", best_ms, exp_best); end
      @(negedge clk);
      n_checks++;
      if (result_valid !== 1'b0) begin n_errors++; $display("FAIL error_pulse_end: got %b expected 0", result_valid); end
      react_btn = 2'b00;
      exp_state = S_ERR;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if ({state, led, time_ms, best_ms, winner, false_start, timeout, result_valid} !==
          {S_IDLE, 1'b0, 14'd0, 14'h3FFF, 2'd0, 3'b000})
      begin n_errors++; $display("FAIL reset_values: st %0d led %b t %0d best %h w %0d fs/to/rv %b", state, led, time_ms, best_ms, winner, {false_start, timeout, result_valid}); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (state !== S_IDLE) begin n_errors++; $display("FAIL idle_after_reset: got %0d expected %0d", state, S_IDLE); end
   endtask

   task automatic test_basic();
      run_round(26, 2'b10, 1'b0);
   endtask

   task automatic test_false_start();
      false_start_round(2'b01);
   endtask

   task automatic test_timeout();
      run_round(-1, 2'b00, 1'b0);
      run_round(76, 2'b10, 1'b0);
      run_round(77, 2'b01, 1'b0);
   endtask

   task automatic test_mid_reset();
      int d;
      start_round(d);
      wait_for_go(d);
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      start_btn = 1'b1;
      #1;
      n_checks++;
      if ({state, led, time_ms, best_ms, winner, false_start, timeout, result_valid} !==
          {S_IDLE, 1'b0, 14'd0, 14'h3FFF, 2'd0, 3'b000})
      begin n_errors++; $display("FAIL async_reset: st %0d led %b t %0d best %h w %0d fs/to/rv %b", state, led, time_ms, best_ms, winner, {false_start, timeout, result_valid}); end
      exp_time = 0; exp_best = 16383; exp_winner = 0; exp_state = S_IDLE;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      n_checks++;
      if (state !== S_IDLE) begin n_errors++; $display("FAIL held_start_ignored: got %0d expected %0d", state, S_IDLE); end
      start_btn = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (state !== S_IDLE) begin n_errors++; $display("FAIL release_no_edge: got %0d expected %0d", state, S_IDLE); end
   endtask

   task automatic test_best_sequence();
      run_round(34, 2'b01, 1'b0);
      run_round(18, 2'b10, 1'b0);
      run_round(18, 2'b11, 1'b0);
   endtask

   task automatic test_random();
      int          k;
      logic [1:0]  who;
      for (int r = 0; r < 8; r++) begin
         k   = int'($urandom_range(0, 3));
         who = 2'($urandom_range(1, 3));
         if (k == 0)      false_start_round(who);
         else if (k == 3) run_round(-1, 2'b00, 1'b0);
         else             run_round(int'($urandom_range(0, 77)), who, 1'b0);
      end
   endtask

   task automatic test_ignored();
      int held = 0;
      run_round(12, 2'b10, 1'b1);
      react_btn = 2'b01;
      repeat (8) begin
         @(negedge clk);
         if (state === S_DONE && result_valid === 1'b0) held++;
      end
      n_checks++;
      if (held != 8) begin n_errors++; $display("FAIL react_in_done_ignored: stable cycles %0d expected 8", held); end
      n_checks++;
      if (winner !== 2'(exp_winner)) begin n_errors++; $display("FAIL winner_after_ignored: got %0d expected %0d", winner, exp_winner); end
      react_btn = 2'b00;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_timeout();
      test_mid_reset();
      test_best_sequence();
      test_random();
      test_ignored();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multi_reaction_timer.md
MULTI_REACTION_TIMER -- requirements
Module: multi_reaction_timer

Interface
REQ-001 Parameter N_PLAYERS, default 2; number of reaction-button channels, legal range 1..4.
REQ-002 Parameter CLK_PER_MS, default 10000; clock cycles per millisecond tick, minimum 2.
REQ-003 Parameter MIN_DELAY_MS, default 1000; minimum random pre-GO delay in ms.
REQ-004 Parameter DELAY_SPAN_LOG2, default 11; random delay span is 2**DELAY_SPAN_LOG2 ms.
REQ-005 Parameter MAX_MS, default 9999; GO-phase saturation/timeout value, at most 16383.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start_btn  input  1  raw start button, asynchronous to clk.
REQ-009 react_btn  input  N_PLAYERS  raw per-player reaction buttons, asynchronous to clk.
REQ-010 led  output  1  GO indicator; high only in GO.
REQ-011 time_ms  output  14  current or last reaction time in ms.
REQ-012 best_ms  output  14  lowest valid reaction time since reset; 14'h3FFF means none.
REQ-013 winner  output  2  index of the player who reacted first or false-started.
REQ-014 false_start  output  1  high in ERROR.
REQ-015 timeout  output  1  high in DONE when no player reacted.
REQ-016 result_valid  output  1  one-cycle pulse on entry to DONE or ERROR.
REQ-017 state  output  3  encoded FSM state for debug/display.

Function
REQ-018 Each button passes through a 2-flop synchroniser and a rising-edge detector; only detected edges act. Edge latency from pin is 3 cycles.
REQ-019 A free-running ms prescaler counts 0..CLK_PER_MS-1 and emits a 1-cycle tick at wrap. It restarts at 0 on every entry to WAIT or GO.
REQ-020 A 16-bit Fibonacci LFSR uses taps 16,14,13,11, is seeded 16'hACE1, and advances every cycle. It never holds zero.
REQ-021 FSM states are IDLE=0, WAIT=1, GO=2, DONE=3 and ERROR=4. Encodings 5..7 are unreachable and recover to IDLE on the next cycle.
REQ-022 In IDLE, DONE or ERROR, a start edge moves the FSM to WAIT. It loads delay_cnt = MIN_DELAY_MS + LFSR[DELAY_SPAN_LOG2-1:0], clears false_start/timeout and holds winner.
REQ-023 In WAIT, delay_cnt decrements on each tick. When delay_cnt reaches 0, the next cycle enters GO, sets led=1 and clears time_ms to 0.
REQ-024 In WAIT, any react edge enters ERROR. winner is the lowest-index asserting player; time_ms holds and best_ms is unchanged.
REQ-025 In GO, time_ms increments by 1 per tick.
REQ-026 In GO, the first react edge enters DONE with winner set to the lowest index among simultaneous edges. time_ms freezes at its value in that cycle.
REQ-027 In GO, if time_ms reaches MAX_MS with no react edge, the FSM enters DONE with timeout=1 and time_ms=MAX_MS. best_ms is not updated.
REQ-028 On a non-timeout DONE entry, best_ms becomes time_ms if time_ms < best_ms. Equal times do not update.
REQ-029 A react edge and a tick in the same GO cycle record the pre-increment time_ms.
REQ-030 Start edges in WAIT or GO are ignored. React edges in IDLE, DONE or ERROR are ignored.
REQ-031 result_valid is high for exactly one cycle, in the first cycle of DONE or ERROR.

Reset
REQ-032 Asserting rst_n low immediately, including mid-round, forces the following values. state=IDLE, led=0, time_ms=0, best_ms=14'h3FFF, winner=0, false_start=0, timeout=0, result_valid=0. Also LFSR=16'hACE1, prescaler=0, delay_cnt=0, synchronisers=0.
REQ-033 The first start edge after rst_n deassertion is detected normally. A button held through reset produces no edge until it is released and pressed again.

Structure
REQ-034 The state encoding, the 14'h3FFF "no best" constant and the LFSR seed and taps live in the shared package reaction_pkg.
REQ-035 The synchroniser and edge detector form one sub-module, btn_sync_edge, instantiated 1+N_PLAYERS times. The timer, LFSR and FSM stay in this module.

Verification (CLK_PER_MS=4, MIN_DELAY_MS=2, DELAY_SPAN_LOG2=2, MAX_MS=20, N_PLAYERS=2)
REQ-036 Release reset, pulse start, wait for led high, press react[1] 7 ticks later -> DONE, time_ms=7, winner=1, best_ms=7, result_valid one cycle.
REQ-037 Press react[0] while in WAIT -> ERROR, false_start=1, winner=0, best_ms unchanged, led never high.
REQ-038 Go to GO, press nothing -> DONE at time_ms=20, timeout=1, best_ms unchanged.
REQ-039 Rounds of 9, 5 and 5 ms -> best_ms sequence 9, 5, 5; press react[0] and react[1] in the same cycle -> winner=0.
REQ-040 Assert rst_n low during GO -> all outputs at reset values asynchronously; hold start high through release -> no WAIT entry until start is re-pressed.
